red_pitaya_pwm_ramp: RTL and testbench
======================================

RED_PITAYA_PWM_RAMP -- requirements
Module: red_pitaya_pwm_ramp

Interface
REQ-001 SHALL have parameter CCW, default 24, PWM DAC config word width.
REQ-002 SHALL have parameter PRW, default 16, prescaler and step register width.
REQ-003 SHALL have port clk_i  in  1  system clock; single clock domain.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports sys_addr in 32, sys_wdata in 32, sys_sel in 4, sys_wen in 1, sys_ren in 1: system bus request.
REQ-006 SHALL have ports sys_rdata out 32, sys_err out 1, sys_ack out 1: system bus response.
REQ-007 SHALL have ports dac_a_o, dac_b_o, dac_c_o, dac_d_o  out  CCW  current PWM DAC config words.
REQ-008 SHALL have port busy_o  out  4  per-channel flag, bit n = (current != target), channel a = bit 0.

Function
REQ-009 SHALL decode sys_addr[19:0]: 0x00-0x0C target a-d; 0x10-0x1C step a-d (PRW bits); 0x20 prescaler (PRW bits); 0x24 control, bit0 enable; 0x28 busy (read-only); 0x30-0x3C current a-d.
REQ-010 SHALL assert sys_ack one cycle after any cycle with sys_wen or sys_ren; sys_rdata registered in that cycle; unmapped addresses read 0; sys_err constantly 0.
REQ-011 SHALL use one FSM: IDLE, UPD_A, UPD_B, UPD_C, UPD_D; UPD_x advance unconditionally one per cycle; UPD_D -> IDLE.
REQ-012 SHALL run prescaler counter only in IDLE with enable=1; when counter equals prescaler value, FSM goes to UPD_A and counter clears; update period = prescaler+5 cycles.
REQ-013 SHALL, with enable=0, hold counter at 0 and remain in IDLE; clearing enable mid-sweep lets the sweep finish to IDLE.
REQ-014 SHALL share one 25-bit add/subtract-and-compare unit among channels; only the channel selected by the FSM state updates.
REQ-015 SHALL update: cur<tgt -> min(cur+step, tgt); cur>tgt -> max(cur-step, tgt); cur==tgt -> unchanged; no wrap-around at 0 or 2^CCW-1.
REQ-016 SHALL treat step=0 as jump: cur takes tgt in that channel's update cycle.
REQ-017 SHALL use the target value registered before the update cycle; target write in the same cycle takes effect at the next sweep.
REQ-018 SHALL let a bus write to a current register (0x30-0x3C) override the shared unit when both hit the same channel in the same cycle.
REQ-019 SHALL drive dac_x_o directly from the current registers (zero added latency); busy_o combinational from current/target.

Reset
REQ-020 SHALL, on rst_i high, immediately clear current, target, step, prescaler, enable, counter, sys_rdata, sys_ack to 0 and FSM to IDLE, including mid-sweep.
REQ-021 SHALL resume only via bus configuration after rst_i deasserts; no automatic ramping.

Configuration
REQ-022 SHALL support macro PWM_RAMP_DONE_IRQ_EN: when defined, output port done_o (1 bit) pulses high one cycle when busy_o goes from nonzero to 0; reset value 0.
REQ-023 SHALL, without PWM_RAMP_DONE_IRQ_EN, omit port done_o and its logic; all other behaviour identical.

Verification
REQ-024 SHALL cover reset: assert rst_i mid-sweep -> dac_a_o..dac_d_o, busy_o, sys_ack all 0 in same cycle, FSM IDLE.
REQ-025 SHALL cover up-ramp: prescaler=9, step a=0x100, target a=0x000400, enable=1 -> dac_a_o steps 0x100 every 14 cycles, reaches 0x400 after 4 updates, busy_o[0] falls.
REQ-026 SHALL cover saturation: current a=0xFFFF00, target 0xFFFFFF, step 0x200 -> dac_a_o=0xFFFFFF after one update, never wraps.
REQ-027 SHALL cover jump and down-ramp: current b=0x800000, target 0x000010, step 0 -> dac_b_o=0x000010 in UPD_B of first sweep.
REQ-028 SHALL cover collision: bus write 0x123456 to 0x30 in same cycle as UPD_A -> dac_a_o=0x123456 next cycle.
REQ-029 SHALL cover bus: read 0x40 -> sys_rdata=0, sys_ack one cycle later, sys_err=0; with PWM_RAMP_DONE_IRQ_EN, last channel settling -> done_o single-cycle pulse.

Source files
------------

// File: rtl/red_pitaya_pwm_ramp.sv
// Four-channel PWM DAC config-word ramp generator with bus-mapped target/step/prescaler registers.
// Define PWM_RAMP_DONE_IRQ_EN to add the done_o pulse when all channels have settled.
module red_pitaya_pwm_ramp #(
    parameter int CCW = 24,
    parameter int PRW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic [3:0]     sys_sel,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_err,
    output logic           sys_ack,
    output logic [CCW-1:0] dac_a_o,
    output logic [CCW-1:0] dac_b_o,
    output logic [CCW-1:0] dac_c_o,
    output logic [CCW-1:0] dac_d_o,
`ifdef PWM_RAMP_DONE_IRQ_EN
    output logic [3:0]     busy_o,
    output logic           done_o
`else
    output logic [3:0]     busy_o
`endif
);

    typedef enum logic [2:0] {IDLE, UPD_A, UPD_B, UPD_C, UPD_D} state_t;

    state_t         state;
    logic [CCW-1:0] cur [4];
    logic [CCW-1:0] tgt [4];
    logic [PRW-1:0] stp [4];
    logic [PRW-1:0] presc;
    logic [PRW-1:0] cnt;
    logic           enable;

    logic [19:0]    addr;
    logic [1:0]     idx;
    logic           wr_tgt, wr_stp, wr_cur, wr_presc, wr_ctrl;
    logic [31:0]    rd_val;
    logic           upd;
    logic [1:0]     sel;
    logic [CCW-1:0] nxt;
    logic           unused_bits;

    // One move towards t: a carry/borrow out or crossing t means the step overshoots, so land on t.
    function automatic logic [CCW-1:0] ramp_step(input logic [CCW-1:0] c,
                                                 input logic [CCW-1:0] t,
                                                 input logic [PRW-1:0] s);
        logic [CCW:0] s_x;
        logic [CCW:0] r;
        logic         dn;
        logic         past;
        s_x  = {{(CCW+1-PRW){1'b0}}, s};
        dn   = (c > t);
        r    = dn ? ({1'b0, c} - s_x) : ({1'b0, c} + s_x);
        past = r[CCW] || (dn ? (r[CCW-1:0] <= t) : (r[CCW-1:0] >= t));
        if (s == '0 || c == t || past) return t;
        return r[CCW-1:0];
    endfunction

    assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:CCW]};

    always_comb begin
        addr     = sys_addr[19:0];
        idx      = addr[3:2];
        wr_tgt   = sys_wen && (addr[19:4] == 16'h0000) && (addr[1:0] == 2'b00);
        wr_stp   = sys_wen && (addr[19:4] == 16'h0001) && (addr[1:0] == 2'b00);
        wr_cur   = sys_wen && (addr[19:4] == 16'h0003) && (addr[1:0] == 2'b00);
        wr_presc = sys_wen && (addr == 20'h00020);
        wr_ctrl  = sys_wen && (addr == 20'h00024);
    end

    always_comb begin
        upd = 1'b1;
        sel = 2'd0;
        case (state)
            UPD_A:   sel = 2'd0;
            UPD_B:   sel = 2'd1;
            UPD_C:   sel = 2'd2;
            UPD_D:   sel = 2'd3;
            default: upd = 1'b0;
        endcase
        nxt = ramp_step(cur[sel], tgt[sel], stp[sel]);
    end

    always_comb begin
        rd_val = '0;
        if (addr[1:0] == 2'b00) begin
            case (addr[19:4])
                16'h0000: rd_val = {{(32-CCW){1'b0}}, tgt[idx]};
                16'h0001: rd_val = {{(32-PRW){1'b0}}, stp[idx]};
                16'h0002: begin
                    case (idx)
                        2'd0:    rd_val = {{(32-PRW){1'b0}}, presc};
                        2'd1:    rd_val = {31'd0, enable};
                        2'd2:    rd_val = {28'd0, busy_o};
                        default: rd_val = '0;
                    endcase
                end
                16'h0003: rd_val = {{(32-CCW){1'b0}}, cur[idx]};
                default:  rd_val = '0;
            endcase
        end
    end

    // Register file; a bus write to a current register wins over the ramp unit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                cur[i] <= '0;
                tgt[i] <= '0;
                stp[i] <= '0;
            end
            presc  <= '0;
            enable <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_cur && idx == 2'(i))
                    cur[i] <= sys_wdata[CCW-1:0];
                else if (upd && sel == 2'(i))
                    cur[i] <= nxt;
                if (wr_tgt && idx == 2'(i))
                    tgt[i] <= sys_wdata[CCW-1:0];
                if (wr_stp && idx == 2'(i))
                    stp[i] <= sys_wdata[PRW-1:0];
            end
            if (wr_presc)
                presc <= sys_wdata[PRW-1:0];
            if (wr_ctrl)
                enable <= sys_wdata[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable) begin
                        cnt <= '0;
                    end else if (cnt == presc) begin
                        cnt   <= '0;
                        state <= UPD_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UPD_A:   state <= UPD_B;
                UPD_B:   state <= UPD_C;
                UPD_C:   state <= UPD_D;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack <= sys_wen | sys_ren;
            if (sys_ren)
                sys_rdata <= rd_val;
        end
    end

    assign sys_err = 1'b0;
    assign dac_a_o = cur[0];
    assign dac_b_o = cur[1];
    assign dac_c_o = cur[2];
    assign dac_d_o = cur[3];

    always_comb begin
        for (int i = 0; i < 4; i++)
            busy_o[i] = (cur[i] != tgt[i]);
    end

`ifdef PWM_RAMP_DONE_IRQ_EN
    logic [3:0] busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            busy_q <= '0;
        else
            busy_q <= busy_o;
    end

    assign done_o = (|busy_q) && !(|busy_o);
`endif

endmodule

// File: tb/tb_red_pitaya_pwm_ramp.sv
// Bench for red_pitaya_pwm_ramp: register-level model checked every cycle plus directed ramp scenarios.
module tb_red_pitaya_pwm_ramp;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_wdata = '0;
    logic [3:0]  sys_sel = 4'hF;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;
    logic [23:0] dac_a, dac_b, dac_c, dac_d;
    logic [3:0]  busy;
`ifdef PWM_RAMP_DONE_IRQ_EN
    logic        done;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    logic run_chk = 1'b0;

    always #5 clk = ~clk;

    red_pitaya_pwm_ramp dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_sel   (sys_sel),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack),
        .dac_a_o   (dac_a),
        .dac_b_o   (dac_b),
        .dac_c_o   (dac_c),
        .dac_d_o   (dac_d),
        .busy_o    (busy)
`ifdef PWM_RAMP_DONE_IRQ_EN
        , .done_o  (done)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register-level model: integer registers, a sweep every presc+5 cycles, clamped moves.
    int          m_cur[4], m_tgt[4], m_stp[4];
    int          m_presc, m_en, m_idle, m_ch;
    logic        m_ack;
    logic [31:0] m_rdata;

    function automatic int settle(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (m_cur[i] != m_tgt[i]);
        return b;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [19:0] o;
        o = a[19:0];
        if (o[1:0] != 2'b00) return 32'h0;
        if (o < 20'h10) return m_tgt[o[3:2]];
        if (o < 20'h20) return m_stp[o[3:2]];
        if (o == 20'h20) return m_presc;
        if (o == 20'h24) return m_en;
        if (o == 20'h28) return {28'h0, m_busy()};
        if (o >= 20'h30 && o < 20'h40) return m_cur[o[3:2]];
        return 32'h0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        logic [19:0] o;
        o = a[19:0];
        if (o[1:0] != 2'b00) return;
        if (o < 20'h10) m_tgt[o[3:2]] = d & 32'hFF_FFFF;
        else if (o < 20'h20) m_stp[o[3:2]] = d & 32'hFFFF;
        else if (o == 20'h20) m_presc = d & 32'hFFFF;
        else if (o == 20'h24) m_en = d & 32'h1;
        else if (o >= 20'h30 && o < 20'h40) m_cur[o[3:2]] = d & 32'hFF_FFFF;
    endtask

    always @(posedge clk or posedge rst_i) begin : model
        int nxt_ch;
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                m_cur[i] = 0; m_tgt[i] = 0; m_stp[i] = 0;
            end
            m_presc = 0; m_en = 0; m_idle = 0; m_ch = -1;
            m_ack = 1'b0; m_rdata = '0;
        end else begin
            nxt_ch = m_ch;
            if (m_ch < 0) begin
                if (m_en == 0) m_idle = 0;
                else if (m_idle == m_presc) begin m_idle = 0; nxt_ch = 0; end
                else m_idle++;
            end else begin
                nxt_ch = (m_ch == 3) ? -1 : m_ch + 1;
            end
            m_ack = sys_wen | sys_ren;
            if (sys_ren) m_rdata = m_read(sys_addr);
            if (m_ch >= 0) m_cur[m_ch] = settle(m_cur[m_ch], m_tgt[m_ch], m_stp[m_ch]);
            if (sys_wen) m_write(sys_addr, sys_wdata);
            m_ch = nxt_ch;
        end
    end

    always @(posedge clk) begin
        #1;
        if (run_chk && !rst_i) begin
            check("dac_a", 32'(dac_a), m_cur[0]);
            check("dac_b", 32'(dac_b), m_cur[1]);
            check("dac_c", 32'(dac_c), m_cur[2]);
            check("dac_d", 32'(dac_d), m_cur[3]);
            check("busy", 32'(busy), 32'(m_busy()));
            check("ack", 32'(sys_ack), 32'(m_ack));
            check("err", 32'(sys_err), 32'h0);
            if (m_ack) check("rdata", sys_rdata, m_rdata);
        end
    end

`ifdef PWM_RAMP_DONE_IRQ_EN
    logic [3:0] last_busy = '0;
    always @(posedge clk) begin
        #1;
        if (run_chk && !rst_i)
            check("done", 32'(done), 32'((last_busy != 4'h0) && (m_busy() == 4'h0)));
        last_busy = rst_i ? 4'h0 : m_busy();
    end
`endif

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        @(posedge clk); #1;
        check({name, "_ack"}, 32'(sys_ack), 32'h1);
        check(name, sys_rdata, exp);
        check({name, "_err"}, 32'(sys_err), 32'h0);
        @(negedge clk);
        sys_ren = 1'b0;
        @(posedge clk); #1;
        check({name, "_ack_drop"}, 32'(sys_ack), 32'h0);
    endtask

    task automatic quiesce();
        bus_write(32'h24, 32'h0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] prev;
        int          t_chg[$];
        logic [23:0] v_chg[$];
        int          got;

        #3 rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_dac_a", 32'(dac_a), 32'h0);
        check("rst_dac_d", 32'(dac_d), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack", 32'(sys_ack), 32'h0);
        run_chk = 1'b1;

        // Up-ramp: 0x100 per update, one update every 9+5 cycles.
        bus_write(32'h20, 32'd9);
        bus_write(32'h10, 32'h100);
        bus_write(32'h00, 32'h400);
        bus_write(32'h24, 32'h1);
        prev = dac_a;
        for (int c = 0; c < 200 && v_chg.size() < 4; c++) begin
            @(posedge clk); #1;
            if (dac_a != prev) begin
                t_chg.push_back(c);
                v_chg.push_back(dac_a);
                prev = dac_a;
                if (v_chg.size() == 1) check("up_busy_mid", 32'(busy[0]), 32'h1);
            end
        end
        check("up_count", v_chg.size(), 4);
        for (int k = 0; k < v_chg.size(); k++)
            check("up_value", 32'(v_chg[k]), 32'h100 * (k + 1));
        for (int k = 1; k < t_chg.size(); k++)
            check("up_period", t_chg[k] - t_chg[k-1], 14);
        check("up_busy_end", 32'(busy[0]), 32'h0);

        // Saturation at the top of the range.
        quiesce();
        bus_write(32'h30, 32'hFFFF00);
        bus_write(32'h10, 32'h200);
        bus_write(32'h00, 32'hFFFFFF);
        bus_write(32'h24, 32'h1);
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(posedge clk); #1;
            if (dac_a != 24'hFFFF00) got = 1;
        end
        check("sat_seen", got, 1);
        check("sat_first", 32'(dac_a), 32'hFFFFFF);
        repeat (30) @(negedge clk);
        check("sat_hold", 32'(dac_a), 32'hFFFFFF);

        // Jump on b (step 0) and clamped down-ramp on c.
        quiesce();
        bus_write(32'h34, 32'h800000);
        bus_write(32'h14, 32'h0);
        bus_write(32'h04, 32'h10);
        bus_write(32'h38, 32'h150);
        bus_write(32'h18, 32'h100);
        bus_write(32'h08, 32'h10);
        bus_write(32'h24, 32'h1);
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(posedge clk); #1;
            if (dac_c != 24'h150) got = 1;
        end
        check("dn_seen1", got, 1);
        check("jump_b", 32'(dac_b), 32'h10);
        check("dn_c1", 32'(dac_c), 32'h50);
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(posedge clk); #1;
            if (dac_c != 24'h50) got = 1;
        end
        check("dn_seen2", got, 1);
        check("dn_c2", 32'(dac_c), 32'h10);
        check("dn_busy", 32'(busy), 32'h0);

        // Bus write to current a collides with the UPD_A cycle.
        quiesce();
        bus_write(32'h20, 32'd2);
        bus_write(32'h30, 32'h400);
        bus_write(32'h10, 32'h100);
        bus_write(32'h00, 32'h0);
        bus_write(32'h24, 32'h1);
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            @(negedge clk);
            if (m_ch == 0) got = 1;
        end
        check("coll_sync", got, 1);
        sys_addr = 32'h30; sys_wdata = 32'h123456; sys_wen = 1'b1;
        @(posedge clk); #1;
        check("coll_dac_a", 32'(dac_a), 32'h123456);
        @(negedge clk);
        sys_wen = 1'b0;

        // Register reads.
        bus_read("rd_unmapped", 32'h40, 32'h0);
        bus_read("rd_presc", 32'h20, 32'h2);
        bus_read("rd_busy", 32'h28, 32'h1);
        bus_read("rd_cur_b", 32'h34, 32'h10);
        bus_read("rd_tgt_c", 32'h08, 32'h10);

        // Reset in the middle of a sweep, with an ack pending.
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            @(negedge clk);
            if (m_ch == 0) got = 1;
        end
        check("rst_sync", got, 1);
        sys_addr = 32'h30; sys_ren = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", 32'(sys_ack), 32'h1);
        #1 rst_i = 1'b1;
        #1;
        check("mid_rst_dac_a", 32'(dac_a), 32'h0);
        check("mid_rst_dac_b", 32'(dac_b), 32'h0);
        check("mid_rst_dac_c", 32'(dac_c), 32'h0);
        check("mid_rst_dac_d", 32'(dac_d), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ack", 32'(sys_ack), 32'h0);
        check("mid_rst_rdata", sys_rdata, 32'h0);
        @(negedge clk);
        sys_ren = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_dac_a", 32'(dac_a), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        bus_read("post_rst_ctrl", 32'h24, 32'h0);
        bus_read("post_rst_step", 32'h10, 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
